// File: rtl/div_share_ctrl_if.sv
// div_share_ctrl_if
//   Bundles the requester side (request/response handshakes) and the divider
//   side of the shared divider controller.
//   Modports:
//     slave  - the controller: takes requests, drives grants, responses and
//              the divider control/operands, reads divider result/done.
//     master - the environment (issue ports and divider core), the mirror.
//   Signals:
//     req_valid/req_ready  NREQ      request handshake, ready is a one-hot grant
//     req_op               2*NREQ    op of requester i at [2i+1:2i]
//     req_a/req_b          N*NREQ    operands of requester i at [N*i+N-1:N*i]
//     rsp_valid/rsp_ready  NREQ      response handshake, valid is one-hot
//     rsp_data             N         result
//     div_rst              1         divider held idle while high
//     div_op/div_dividend/div_divisor  operands to divider
//     div_out/div_done     divider result and completion
interface div_share_ctrl_if #(
  parameter int N    = 32,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [N*NREQ-1:0] req_a;
  logic [N*NREQ-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [N-1:0]      rsp_data;
  logic              div_rst;
  logic [1:0]        div_op;
  logic [N-1:0]      div_dividend;
  logic [N-1:0]      div_divisor;
  logic [N-1:0]      div_out;
  logic              div_done;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, div_out, div_done,
    output req_ready, rsp_valid, rsp_data, div_rst, div_op, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, div_out, div_done,
    input  req_ready, rsp_valid, rsp_data, div_rst, div_op, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_share_ctrl.sv
// div_share_ctrl
//   Shares one iterative divider core (op 00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   among NREQ requesters. One operation in flight: a round-robin grant in
//   IDLE captures the request, BUSY releases the divider reset with frozen
//   operands until div_done, RESP holds the result to the owner until it is
//   accepted.
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset
//     bus  - div_share_ctrl_if.slave (request, response and divider signals)
//   Build option:
//     DIV_SHARE_CACHE_EN - keeps the last {op, a, b, result}; an exact repeat
//                          of that request skips the divider and goes straight
//                          to RESP. Undefined: every request uses the divider.
//
//   state | meaning
//   IDLE  | divider held in reset, round-robin grant open
//   BUSY  | divider running on captured operands, waiting for div_done
//   RESP  | result held on rsp_data, rsp_valid to owner until rsp_ready
module div_share_ctrl #(
  parameter int N    = 32,
  parameter int NREQ = 2
) (
  input  logic          clk,
  input  logic          rst,
  div_share_ctrl_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_rr;
  logic [IW-1:0]   r_owner;
  logic [1:0]      r_op;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_res;

  logic [IW-1:0]   w_win_idx;
  logic            w_win_found;
  logic [IW:0]     w_cand;
  logic [1:0]      w_win_op;
  logic [N-1:0]    w_win_a;
  logic [N-1:0]    w_win_b;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_rsp_valid;
  logic            w_xfer;
  logic            w_hit;

  // Round-robin search starting at r_rr; candidate index is one bit wider so
  // the wrap also works when NREQ is not a power of two.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_rr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NREQ)) w_cand = w_cand - (IW+1)'(NREQ);
      if (!w_win_found && bus.req_valid[w_cand[IW-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand[IW-1:0];
      end
    end
  end

  always_comb begin
    w_win_op = '0;
    w_win_a  = '0;
    w_win_b  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win_idx == IW'(k)) begin
        w_win_op = bus.req_op[2*k +: 2];
        w_win_a  = bus.req_a[N*k +: N];
        w_win_b  = bus.req_b[N*k +: N];
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (r_state == S_IDLE && !rst && w_win_found) w_grant[w_win_idx] = 1'b1;
  end

  assign w_xfer = |(w_grant & bus.req_valid);

`ifdef DIV_SHARE_CACHE_EN
  logic         r_c_valid;
  logic [1:0]   r_c_op;
  logic [N-1:0] r_c_a;
  logic [N-1:0] r_c_b;
  logic [N-1:0] r_c_res;

  assign w_hit = r_c_valid && (w_win_op == r_c_op) && (w_win_a == r_c_a) && (w_win_b == r_c_b);

  // Filled from the captured operands when a divider run completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_valid <= 1'b0;
      r_c_op    <= '0;
      r_c_a     <= '0;
      r_c_b     <= '0;
      r_c_res   <= '0;
    end else if (r_state == S_BUSY && bus.div_done) begin
      r_c_valid <= 1'b1;
      r_c_op    <= r_op;
      r_c_a     <= r_a;
      r_c_b     <= r_b;
      r_c_res   <= bus.div_out;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_xfer) w_state_nxt = w_hit ? S_RESP : S_BUSY;
      S_BUSY: if (bus.div_done) w_state_nxt = S_RESP;
      S_RESP: if (bus.rsp_ready[r_owner]) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr    <= '0;
      r_owner <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else begin
      if (w_xfer) begin
        r_owner <= w_win_idx;
        r_rr    <= (w_win_idx == IW'(NREQ-1)) ? '0 : w_win_idx + IW'(1);
        r_op    <= w_win_op;
        r_a     <= w_win_a;
        r_b     <= w_win_b;
`ifdef DIV_SHARE_CACHE_EN
        if (w_hit) r_res <= r_c_res;
`endif
      end
      if (r_state == S_BUSY && bus.div_done) r_res <= bus.div_out;
    end
  end

  always_comb begin
    w_rsp_valid = '0;
    if (r_state == S_RESP && !rst) w_rsp_valid[r_owner] = 1'b1;
  end

  assign bus.req_ready    = w_grant;
  assign bus.rsp_valid    = w_rsp_valid;
  assign bus.rsp_data     = r_res;
  assign bus.div_rst      = (r_state != S_BUSY);
  assign bus.div_op       = r_op;
  assign bus.div_dividend = r_a;
  assign bus.div_divisor  = r_b;
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl
//   Directed bench for div_share_ctrl with a behavioural divider stand-in
//   (latency N+4 cycles for a nonzero divisor, 3 for a zero divisor).
//   Build with +define+DIV_SHARE_CACHE_EN to include the result-cache case.
module tb_div_share_ctrl;
  localparam int N    = 32;
  localparam int NREQ = 2;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_share_ctrl_if #(.N(N), .NREQ(NREQ)) bus ();

  div_share_ctrl #(.N(N), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] div_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_DIV: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  int m_cnt = 0;
  always @(posedge clk) begin
    if (bus.div_rst) m_cnt <= 0;
    else             m_cnt <= m_cnt + 1;
  end
  assign bus.div_done = !bus.div_rst && (m_cnt == ((bus.div_divisor == 0) ? 3 : N + 4) - 1);
  assign bus.div_out  = div_model(bus.div_op, bus.div_dividend, bus.div_divisor);

  // Divider operands must not move between consecutive BUSY cycles.
  logic        p_busy = 1'b0;
  logic [1:0]  p_op;
  logic [31:0] p_a;
  logic [31:0] p_b;
  int          n_unstable = 0;
  always @(posedge clk) begin
    if (p_busy && !bus.div_rst &&
        (bus.div_op != p_op || bus.div_dividend != p_a || bus.div_divisor != p_b))
      n_unstable <= n_unstable + 1;
    p_busy <= !bus.div_rst;
    p_op   <= bus.div_op;
    p_a    <= bus.div_dividend;
    p_b    <= bus.div_divisor;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[idx]      = v;
    bus.req_op[2*idx +: 2]  = op;
    bus.req_a[32*idx +: 32] = a;
    bus.req_b[32*idx +: 32] = b;
  endtask

  // Waits (bounded) for the grant to idx; returns just before the transfer edge.
  task automatic wait_grant(input string tag, input int idx);
    int k = 0;
    #1;
    while (bus.req_ready !== NREQ'(1 << idx) && k < 100) begin
      tick();
      k++;
    end
    chk(tag, bus.req_ready, 64'(1 << idx));
  endtask

  // Waits (bounded) for the response to idx, counting cycles with div_rst low.
  task automatic wait_rsp(input string tag, input int idx, input logic [31:0] exp_data, input int exp_busy);
    int k = 0;
    int busy = 0;
    while (!bus.rsp_valid[idx] && k < 200) begin
      if (!bus.div_rst) busy++;
      tick();
      k++;
    end
    chk({tag, "_vld"}, bus.rsp_valid, 64'(1 << idx));
    chk({tag, "_data"}, bus.rsp_data, exp_data);
    chk({tag, "_busy"}, busy, exp_busy);
  endtask

  task automatic accept(input int idx);
    bus.rsp_ready[idx] = 1'b1;
    tick();
    bus.rsp_ready[idx] = 1'b0;
    #1;
  endtask

  task automatic run_op(input string tag, input int idx, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data, input int exp_busy);
    set_req(idx, 1'b1, op, a, b);
    wait_grant({tag, "_gnt"}, idx);
    tick();
    set_req(idx, 1'b0, 2'($urandom), $urandom, $urandom);
    wait_rsp(tag, idx, exp_data, exp_busy);
    accept(idx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
    rst = 1'b1;

    // Reset values, with both requesters already asking.
    set_req(0, 1'b1, OP_REM, 32'hFFFF_FFF9, 32'd2);
    set_req(1, 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    tick(); tick(); tick();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_div_rst", bus.div_rst, 1);
    chk("rst_div_op", bus.div_op, 0);
    chk("rst_div_a", bus.div_dividend, 0);
    chk("rst_div_b", bus.div_divisor, 0);

    // Round-robin: req0 first, req1 after req0's response, then req0 again.
    rst = 1'b0;
    #1;
    chk("rr_first", bus.req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 2'($urandom), $urandom, $urandom);
    chk("busy_no_grant", bus.req_ready, 0);
    wait_rsp("rem_neg", 0, 32'hFFFF_FFFF, N + 4);
    accept(0);
    chk("rr_second", bus.req_ready, 2'b10);
    tick();
    set_req(1, 1'b0, 2'($urandom), $urandom, $urandom);
    wait_rsp("div_neg", 1, 32'hFFFF_FFFD, N + 4);
    accept(1);
    chk("data_held_idle", bus.rsp_data, 32'hFFFF_FFFD);

    // Both valid again: req0 wins; its response is stalled with req1 waiting.
    set_req(0, 1'b1, OP_DIVU, 32'd81, 32'd9);
    set_req(1, 1'b1, OP_DIVU, 32'h1234, 32'd0);
    #1;
    chk("rr_wrap", bus.req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 2'($urandom), $urandom, $urandom);
    wait_rsp("stall_op", 0, 32'd9, N + 4);
    bus.rsp_ready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_vld", bus.rsp_valid, 2'b01);
      chk("hold_data", bus.rsp_data, 32'd9);
      chk("hold_no_grant", bus.req_ready, 0);
      tick();
    end
    bus.rsp_ready[1] = 1'b0;
    accept(0);
    chk("grant_after_accept", bus.req_ready, 2'b10);

    // Divide by zero on req1.
    tick();
    set_req(1, 1'b0, 2'($urandom), $urandom, $urandom);
    wait_rsp("divu_zero", 1, 32'hFFFF_FFFF, 3);
    accept(1);
    run_op("remu_zero", 1, OP_REMU, 32'h1234, 32'd0, 32'h1234, 3);

    // Basic DIVU with operand checks at the first BUSY cycle.
    set_req(0, 1'b1, OP_DIVU, 32'd100, 32'd7);
    wait_grant("divu_gnt", 0);
    tick();
    set_req(0, 1'b0, 2'($urandom), $urandom, $urandom);
    chk("busy_div_rst", bus.div_rst, 0);
    chk("busy_op", bus.div_op, OP_DIVU);
    chk("busy_a", bus.div_dividend, 32'd100);
    chk("busy_b", bus.div_divisor, 32'd7);
    wait_rsp("divu_basic", 0, 32'd14, N + 4);
    chk("resp_div_rst", bus.div_rst, 1);
    accept(0);

    // Reset 10 cycles into BUSY after a req0 grant (rr would otherwise be 1).
    set_req(0, 1'b1, OP_DIVU, 32'd500, 32'd5);
    wait_grant("abort_gnt", 0);
    tick();
    set_req(0, 1'b0, 2'($urandom), $urandom, $urandom);
    repeat (10) tick();
    rst = 1'b1;
    set_req(0, 1'b1, OP_DIVU, 32'd50, 32'd5);
    set_req(1, 1'b1, OP_DIVU, 32'd77, 32'd7);
    #1;
    chk("abort_rst_ready", bus.req_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_div_rst", bus.div_rst, 1);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_rr_zero", bus.req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 2'($urandom), $urandom, $urandom);
    set_req(1, 1'b0, 2'($urandom), $urandom, $urandom);
    wait_rsp("after_abort", 0, 32'd10, N + 4);
    accept(0);

`ifdef DIV_SHARE_CACHE_EN
    run_op("cache_fill", 0, OP_DIVU, 32'd1000, 32'd3, 32'd333, N + 4);
    set_req(0, 1'b1, OP_DIVU, 32'd1000, 32'd3);
    wait_grant("cache_hit_gnt", 0);
    tick();
    set_req(0, 1'b0, 2'($urandom), $urandom, $urandom);
    chk("cache_hit_div_rst", bus.div_rst, 1);
    wait_rsp("cache_hit", 0, 32'd333, 0);
    accept(0);
    run_op("cache_miss", 0, OP_DIVU, 32'd1000, 32'd4, 32'd250, N + 4);
`endif

    chk("op_stable", n_unstable, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Sequencer and round-robin arbiter that shares one iterative 32-bit divider core (op 00 DIV, 01 DIVU, 10 REM, 11 REMU) among `NREQ` requesters. It sits between the M-extension issue ports and the divider:
- accepts one request at a time over a valid/ready handshake;
- starts the divider by releasing its reset and holds the operands stable;
- waits for the divider's `done`;
- returns the result on a held valid/ready response channel.

## Interface
Parameters:
- `N`, 32, operand/result width.
- `NREQ`, 2, number of requesters (≥2).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  one-hot grant; the request transfers when `req_valid[i] & req_ready[i]`.
- `req_op`  in  2*NREQ  op of requester i at `[2i+1:2i]`.
- `req_a`  in  N*NREQ  dividend of requester i at `[N*i+N-1:N*i]`.
- `req_b`  in  N*NREQ  divisor of requester i, same packing.
- `rsp_valid`  out  NREQ  one-hot result valid, addressed to the originating requester.
- `rsp_ready`  in  NREQ  per-requester result accept.
- `rsp_data`  out  N  result (quotient or remainder per op).
- `div_rst`  out  1  divider reset; high holds the divider idle.
- `div_op`  out  2  to divider.
- `div_dividend`  out  N  to divider.
- `div_divisor`  out  N  to divider.
- `div_out`  in  N  divider result.
- `div_done`  in  1  divider done; valid only while `div_rst`=0.

## Operation
States:
- **IDLE**
  - `div_rst`=1.
  - Arbitrate among `req_valid` with round-robin priority. The search starts at pointer `rr`.
  - `req_ready` = one-hot of the winner, combinational. It is all-zero when no request is valid or when the state is not IDLE.
  - On a transfer:
    - capture op, a, b and the winner index `owner` into registers;
    - set `rr` = `owner`+1, wrapping NREQ-1 → 0;
    - go to BUSY.
- **BUSY**
  - `div_rst`=0. `div_op`/`div_dividend`/`div_divisor` come from the captured registers and are constant for the whole state.
  - On `div_done`=1: capture `div_out` into `res`, go to RESP.
  - No fixed cycle count is assumed.
- **RESP**
  - `div_rst`=1.
  - `rsp_valid[owner]`=1 and `rsp_data`=`res`, both held stable until `rsp_ready[owner]`=1. Then go to IDLE.
  - `rsp_ready` of non-owners is ignored.
- No new grant occurs in BUSY or RESP. Exactly one operation is in flight.
- `rsp_data` is held at the last result outside RESP.
- Divide-by-zero and overflow results are whatever the divider produces. The controller does not special-case them.
- Operands on `req_*` may change freely after the transfer cycle.

## Timing
- Reset values:
  - state IDLE, `rr`=0, `owner`=0, `res`=0;
  - `req_ready`=0 and `rsp_valid`=0 while `rst`=1;
  - `rsp_data`=0, `div_rst`=1, `div_op`/`div_dividend`/`div_divisor`=0.
- Request accepted at edge t: `div_rst` falls in cycle t+1. The divider sees its first non-reset edge at the end of t+1.
- `div_done` first seen high at cycle d: `rsp_valid` is high in cycle d+1 and `div_rst` is high again in d+1.
- With the current divider core, d − t is N+4 for a nonzero divisor and 3 for a zero divisor.
- Response accepted at the end of cycle r: IDLE in r+1, and a new grant is possible in r+1. There is one bubble cycle between operations.
- `rst` mid-BUSY or mid-RESP:
  - state returns to IDLE and `div_rst` goes to 1 in the next cycle;
  - the in-flight result is dropped and no `rsp_valid` is issued for it;
  - `rr` returns to 0.
- A `req_valid` deassertion by a non-granted requester has no effect. A granted requester must not drop `req_valid` in the grant cycle without transferring.

## Configuration
- `DIV_SHARE_CACHE_EN` defined:
  - Keep one entry {valid, op, a, b, result}. It is written in BUSY→RESP and cleared by `rst`.
  - A transfer whose {op, a, b} exactly matches a valid entry bypasses BUSY: RESP in t+1 with the cached result, and `div_rst` stays 1.
  - `rr` updates as normal.
- Undefined: no cache storage. Every request goes through BUSY.

## Test plan
- Req0 DIVU a=100 b=7 → `rsp_valid[0]` with `rsp_data`=14. `div_rst` is low for exactly the BUSY cycles, and the operands are stable throughout.
- Req0 and req1 both valid on the first cycle after reset: req0 REM a=−7 b=2, req1 DIV a=−7 b=2.
  - Req0 is granted first and gets 0xFFFFFFFF (−1).
  - Req1 is granted after req0's response is accepted and gets 0xFFFFFFFD (−3).
  - With both valid again, req0 is granted next (round-robin).
- Req1 DIVU a=0x1234 b=0 → `rsp_data`=0xFFFFFFFF. Req1 REMU a=0x1234 b=0 → 0x1234.
- `rsp_ready[0]` held low for 5 cycles after `rsp_valid[0]` with `req_valid[1]`=1 → `rsp_valid[0]` and `rsp_data` held, `req_ready`=0 throughout. Req1 is granted the cycle after acceptance.
- `rst` pulsed 10 cycles into BUSY → no `rsp_valid` is issued, `div_rst`=1 the next cycle. A fresh req0 DIVU 50/5 then returns 10.
- With `DIV_SHARE_CACHE_EN` defined: DIVU 1000/3 issued twice → the second response (333) arrives at t+1 and `div_rst` stays 1. DIVU 1000/4 then misses and returns 250.
